// File: rtl/uart_rx_frame_ctrl_if.sv
// Bundle between the UART RX frame controller and its line driver / byte consumer.
// UART_RX_BREAK_DETECT_EN adds the break_detect signal to both modports.
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] prescale;
    logic                  parity_enable;
    logic                  parity_type;
    logic                  two_stop;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;
    logic                  busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                  break_detect;

    modport master (
        output RX_IN, prescale, parity_enable, parity_type, two_stop,
        input  P_DATA, data_valid, parity_error, stop_error, busy, break_detect
    );

    modport slave (
        input  RX_IN, prescale, parity_enable, parity_type, two_stop,
        output P_DATA, data_valid, parity_error, stop_error, busy, break_detect
    );
`else
    modport master (
        output RX_IN, prescale, parity_enable, parity_type, two_stop,
        input  P_DATA, data_valid, parity_error, stop_error, busy
    );

    modport slave (
        input  RX_IN, prescale, parity_enable, parity_type, two_stop,
        output P_DATA, data_valid, parity_error, stop_error, busy
    );
`endif
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: majority-voted sampling, deserialise, parity/stop check.
// Optional UART_RX_BREAK_DETECT_EN adds break_detect and a post-break idle hold.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input logic                 clk_based_on_prescale,
    input logic                 asy_reset,
    uart_rx_frame_ctrl_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [2:0]            smp_q, smp_d;
    logic [DATA_WIDTH-1:0] shr_q, shr_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  pen_q, pen_d;
    logic                  pty_q, pty_d;
    logic                  ts_q, ts_d;
    logic                  pf_q, pf_d;
    logic                  sf_q, sf_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;
    logic                  stop_fail;
    logic                  idle_armed;

    logic [PRESCALE_W-1:0] p_in;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] s0;
    logic [PRESCALE_W-1:0] s2;
    logic [PRESCALE_W-1:0] chk;
    logic [PRESCALE_W-1:0] last;
    logic                  vote;

`ifdef UART_RX_BREAK_DETECT_EN
    logic                  nz_q, nz_d;
    logic                  nz_now;
    logic                  hold_q, hold_d;
    logic                  brk_q, brk_d;

    assign idle_armed = ~hold_q;
    assign bus.break_detect = brk_q;
`else
    assign idle_armed = 1'b1;
`endif

    // Latched bit period and the sample / decision points inside one bit
    assign p_in = (bus.prescale < P_MIN) ? P_MIN : bus.prescale;
    assign half = p_q >> 1;
    assign s0   = half - ONE;
    assign s2   = half + ONE;
    assign chk  = half + PRESCALE_W'(2);
    assign last = p_q - ONE;
    assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) |
                  (smp_q[1] & smp_q[2]);

    assign bus.P_DATA       = pdata_q;
    assign bus.data_valid   = dv_q;
    assign bus.parity_error = pe_q;
    assign bus.stop_error   = se_q;
    assign bus.busy         = (state_q != IDLE);

    // Next-state, counters, sampling and end-of-frame response
    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        p_d       = p_q;
        bit_d     = bit_q;
        smp_d     = smp_q;
        shr_d     = shr_q;
        pdata_d   = pdata_q;
        pen_d     = pen_q;
        pty_d     = pty_q;
        ts_d      = ts_q;
        pf_d      = pf_q;
        sf_d      = sf_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;
        stop_fail = sf_q | ~vote;
`ifdef UART_RX_BREAK_DETECT_EN
        nz_d      = nz_q;
        nz_now    = nz_q | vote;
        hold_d    = hold_q;
        brk_d     = 1'b0;
`endif

        if (state_q != IDLE) begin
            edge_d = (edge_q == last) ? '0 : edge_q + ONE;
            if (edge_q == s0)   smp_d[0] = bus.RX_IN;
            if (edge_q == half) smp_d[1] = bus.RX_IN;
            if (edge_q == s2)   smp_d[2] = bus.RX_IN;
        end

        unique case (state_q)
            IDLE: begin
`ifdef UART_RX_BREAK_DETECT_EN
                if (hold_q) begin
                    if (!bus.RX_IN) begin
                        edge_d = '0;
                    end else if (edge_q == last) begin
                        edge_d = '0;
                        hold_d = 1'b0;
                    end else begin
                        edge_d = edge_q + ONE;
                    end
                end
                nz_d = 1'b0;
`endif
                if (idle_armed && !bus.RX_IN) begin
                    state_d = START;
                    edge_d  = ONE;
                    p_d     = p_in;
                    pen_d   = bus.parity_enable;
                    pty_d   = bus.parity_type;
                    ts_d    = bus.two_stop;
                    bit_d   = '0;
                    pf_d    = 1'b0;
                    sf_d    = 1'b0;
                end
            end
            START: begin
                if (edge_q == chk && vote) begin
                    state_d = IDLE;
                    edge_d  = '0;
                end else if (edge_q == last) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (edge_q == last) begin
                    shr_d = {vote, shr_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
                    nz_d = nz_now;
`endif
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (edge_q == last) begin
                    if (vote != (^shr_q ^ pty_q)) pf_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                    nz_d = nz_now;
`endif
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (edge_q == last) begin
                    sf_d = stop_fail;
`ifdef UART_RX_BREAK_DETECT_EN
                    if (bit_q == '0) nz_d = nz_now;
`endif
                    if (ts_q && bit_q == '0) begin
                        bit_d = BW'(1);
                    end else begin
                        state_d = IDLE;
                        bit_d   = '0;
                        if (!pf_q && !stop_fail) begin
                            pdata_d = shr_q;
                            dv_d    = 1'b1;
                        end else begin
                            pe_d = pf_q;
                            se_d = stop_fail;
                        end
`ifdef UART_RX_BREAK_DETECT_EN
                        brk_d  = ~((bit_q == '0) ? nz_now : nz_q);
                        hold_d = brk_d;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_based_on_prescale) begin
        if (!asy_reset) begin
            state_q <= IDLE;
            edge_q  <= '0;
            p_q     <= P_MIN;
            bit_q   <= '0;
            smp_q   <= '0;
            shr_q   <= '0;
            pdata_q <= '0;
            pen_q   <= 1'b0;
            pty_q   <= 1'b0;
            ts_q    <= 1'b0;
            pf_q    <= 1'b0;
            sf_q    <= 1'b0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            nz_q    <= 1'b0;
            hold_q  <= 1'b0;
            brk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            p_q     <= p_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shr_q   <= shr_d;
            pdata_q <= pdata_d;
            pen_q   <= pen_d;
            pty_q   <= pty_d;
            ts_q    <= ts_d;
            pf_q    <= pf_d;
            sf_q    <= sf_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
`ifdef UART_RX_BREAK_DETECT_EN
            nz_q    <= nz_d;
            hold_q  <= hold_d;
            brk_q   <= brk_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: directed and random frames on 8-bit and 7-bit instances.
// Expected results come from a frame-level model of the serial protocol.
module tb_uart_rx_frame_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) ifa ();
    uart_rx_frame_ctrl_if #(.DATA_WIDTH(7), .PRESCALE_W(6)) ifb ();

    uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut_a (
        .clk_based_on_prescale(clk),
        .asy_reset(rst_n),
        .bus(ifa.slave)
    );

    uart_rx_frame_ctrl #(.DATA_WIDTH(7), .PRESCALE_W(6)) dut_b (
        .clk_based_on_prescale(clk),
        .asy_reset(rst_n),
        .bus(ifb.slave)
    );

    int checks = 0;
    int errors = 0;
    int dv_cnt[2];
    int pe_cnt[2];
    int se_cnt[2];
    int exp_dv[2];
    int exp_pe[2];
    int exp_se[2];
    logic [8:0] exp_pd[2];

    // Pulse counters: widths and stray pulses show up as count differences
    always @(posedge clk) begin
        if (ifa.data_valid)   dv_cnt[0] <= dv_cnt[0] + 1;
        if (ifa.parity_error) pe_cnt[0] <= pe_cnt[0] + 1;
        if (ifa.stop_error)   se_cnt[0] <= se_cnt[0] + 1;
        if (ifb.data_valid)   dv_cnt[1] <= dv_cnt[1] + 1;
        if (ifb.parity_error) pe_cnt[1] <= pe_cnt[1] + 1;
        if (ifb.stop_error)   se_cnt[1] <= se_cnt[1] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input bit sel, input bit v);
        if (sel) ifb.RX_IN = v;
        else ifa.RX_IN = v;
    endtask

    task automatic set_cfg(input bit sel, input int pr, input bit pen, input bit pty, input bit ts);
        if (sel) begin
            ifb.prescale = 6'(pr); ifb.parity_enable = pen;
            ifb.parity_type = pty; ifb.two_stop = ts;
        end else begin
            ifa.prescale = 6'(pr); ifa.parity_enable = pen;
            ifa.parity_type = pty; ifa.two_stop = ts;
        end
    endtask

    task automatic rd(input bit sel, output logic [31:0] pd, output logic dv,
                      output logic pe, output logic se, output logic bz, output logic bk);
        bk = 1'b0;
        if (sel) begin
            pd = 32'(ifb.P_DATA); dv = ifb.data_valid; pe = ifb.parity_error;
            se = ifb.stop_error; bz = ifb.busy;
`ifdef UART_RX_BREAK_DETECT_EN
            bk = ifb.break_detect;
`endif
        end else begin
            pd = 32'(ifa.P_DATA); dv = ifa.data_valid; pe = ifa.parity_error;
            se = ifa.stop_error; bz = ifa.busy;
`ifdef UART_RX_BREAK_DETECT_EN
            bk = ifa.break_detect;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame bit by bit; config is scrambled after the start edge
    task automatic drive_frame(input bit sel, input int pr, input bit pen, input bit pty,
                               input bit ts, input logic [8:0] data, input bit par_bit,
                               input bit st0, input bit st1, input bit noise, input int ncyc);
        int p, half, dw, total, n, flip;
        bit v;
        bit bits[$];
        logic [31:0] pd;
        logic dv, pe, se, bz, bk;
        p = (pr < 8) ? 8 : pr;
        half = p / 2;
        dw = sel ? 7 : 8;
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(par_bit);
        bits.push_back(st0);
        if (ts) bits.push_back(st1);
        total = bits.size() * p;
        n = 0;
        set_cfg(sel, pr, pen, pty, ts);
        for (int i = 0; i < bits.size(); i++) begin
            flip = half - 1 + int'($urandom_range(0, 2));
            for (int c = 0; c < p; c++) begin
                if (n >= ncyc) return;
                v = bits[i];
                if (noise && i >= 1 && i <= dw && c == flip) v = ~v;
                set_line(sel, v);
                if (n == total - 1) begin
                    rd(sel, pd, dv, pe, se, bz, bk);
                    chk("busy_before_end", 32'(bz), 32'd1);
                    chk("no_early_valid", 32'(dv), 32'd0);
                end
                tick();
                if (n == 0) begin
                    rd(sel, pd, dv, pe, se, bz, bk);
                    chk("busy_after_start", 32'(bz), 32'd1);
                    set_cfg(sel, int'($urandom_range(0, 63)), 1'($urandom), 1'($urandom),
                            1'($urandom));
                end
                n++;
            end
        end
    endtask

    // Frame-level model: good frame iff parity matches and every stop bit is 1
    task automatic run_frame(input string tag, input bit sel, input int pr, input bit pen,
                             input bit pty, input bit ts, input logic [8:0] data,
                             input bit bad_par, input bit st0, input bit st1, input bit noise);
        logic [8:0] md;
        bit par_bit, good, pfail, sfail, brk;
        logic [31:0] pd;
        logic dv, pe, se, bz, bk;
        md = sel ? (data & 9'h07f) : (data & 9'h0ff);
        par_bit = (^md) ^ pty ^ bad_par;
        pfail = pen && bad_par;
        sfail = !(st0 && (!ts || st1));
        good = !pfail && !sfail;
        brk = (md == 9'd0) && (!pen || !par_bit) && !st0;
        drive_frame(sel, pr, pen, pty, ts, md, par_bit, st0, st1, noise, 1 << 30);
        set_line(sel, 1'b1);
        if (good) begin
            exp_pd[sel] = md;
            exp_dv[sel]++;
        end
        if (pfail) exp_pe[sel]++;
        if (sfail) exp_se[sel]++;
        rd(sel, pd, dv, pe, se, bz, bk);
        chk({tag, "_valid"}, 32'(dv), 32'(good));
        chk({tag, "_perr"}, 32'(pe), 32'(pfail));
        chk({tag, "_serr"}, 32'(se), 32'(sfail));
        chk({tag, "_pdata"}, pd, 32'(exp_pd[sel]));
        chk({tag, "_busy"}, 32'(bz), 32'd0);
`ifdef UART_RX_BREAK_DETECT_EN
        chk({tag, "_break"}, 32'(bk), 32'(brk));
`else
        if (brk) $display("break frame %s reported as stop error", tag);
`endif
    endtask

    initial begin
        logic [31:0] pd;
        logic dv, pe, se, bz, bk;
        bit sel, pen, pty, ts, bad, st0, st1, noise;
        int pr;
        logic [8:0] data;

        rst_n = 1'b0;
        set_line(0, 1'b1);
        set_line(1, 1'b1);
        set_cfg(0, 8, 0, 0, 0);
        set_cfg(1, 8, 0, 0, 0);
        exp_pd[0] = '0;
        exp_pd[1] = '0;
        repeat (3) tick();
        rd(0, pd, dv, pe, se, bz, bk);
        chk("reset_pdata", pd, 32'd0);
        chk("reset_valid", 32'(dv), 32'd0);
        chk("reset_perr", 32'(pe), 32'd0);
        chk("reset_serr", 32'(se), 32'd0);
        chk("reset_busy", 32'(bz), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        run_frame("a5_8n1", 0, 8, 0, 0, 0, 9'h0a5, 0, 1, 1, 0);
        repeat (3) tick();

        run_frame("b_good", 1, 16, 1, 0, 1, 9'h02a, 0, 1, 1, 0);
        repeat (2) tick();
        run_frame("b_parerr", 1, 16, 1, 0, 1, 9'h055, 1, 1, 1, 0);
        repeat (2) tick();

        set_cfg(0, 8, 0, 0, 0);
        set_line(0, 1'b0);
        repeat (3) tick();
        set_line(0, 1'b1);
        repeat (3) tick();
        rd(0, pd, dv, pe, se, bz, bk);
        chk("glitch_busy_e5", 32'(bz), 32'd1);
        tick();
        rd(0, pd, dv, pe, se, bz, bk);
        chk("glitch_busy_e6", 32'(bz), 32'd0);
        repeat (3) tick();
        run_frame("after_glitch", 0, 8, 0, 0, 0, 9'h03c, 0, 1, 1, 0);
        repeat (2) tick();

        run_frame("stop0", 0, 8, 0, 0, 0, 9'h0a5, 0, 0, 1, 0);
        repeat (2) tick();
        run_frame("break", 0, 8, 0, 0, 0, 9'h000, 0, 0, 0, 0);
`ifdef UART_RX_BREAK_DETECT_EN
        repeat (4) tick();
        set_line(0, 1'b0);
        tick();
        set_line(0, 1'b1);
        rd(0, pd, dv, pe, se, bz, bk);
        chk("break_hold_busy", 32'(bz), 32'd0);
`endif
        repeat (10) tick();

        drive_frame(0, 8, 0, 0, 0, 9'h012, 0, 1, 1, 0, 40);
        rst_n = 1'b0;
        set_line(0, 1'b1);
        tick();
        exp_pd[0] = '0;
        exp_pd[1] = '0;
        rd(0, pd, dv, pe, se, bz, bk);
        chk("midrst_pdata", pd, 32'd0);
        chk("midrst_valid", 32'(dv), 32'd0);
        chk("midrst_serr", 32'(se), 32'd0);
        chk("midrst_busy", 32'(bz), 32'd0);
        rst_n = 1'b1;
        tick();
        run_frame("ff_after_rst", 0, 8, 0, 0, 0, 9'h0ff, 0, 1, 1, 0);
        repeat (2) tick();

        run_frame("noise_0f", 0, 8, 0, 0, 0, 9'h00f, 0, 1, 1, 1);
        repeat (2) tick();

        for (int k = 0; k < 40; k++) begin
            sel = ($urandom_range(0, 3) == 0);
            pr = int'($urandom_range(4, 20));
            pen = 1'($urandom);
            pty = 1'($urandom);
            ts = 1'($urandom);
            data = 9'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            st0 = ($urandom_range(0, 5) != 0);
            st1 = ($urandom_range(0, 5) != 0);
            noise = 1'($urandom);
            if (!st0 && ((sel ? (data & 9'h07f) : (data & 9'h0ff)) == 9'd0)) data[0] = 1'b1;
            run_frame("rand", sel, pr, pen, pty, ts, data, bad, st0, st1, noise);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (4) tick();
        chk("cnt_valid_a", 32'(dv_cnt[0]), 32'(exp_dv[0]));
        chk("cnt_perr_a", 32'(pe_cnt[0]), 32'(exp_pe[0]));
        chk("cnt_serr_a", 32'(se_cnt[0]), 32'(exp_se[0]));
        chk("cnt_valid_b", 32'(dv_cnt[1]), 32'(exp_dv[1]));
        chk("cnt_perr_b", 32'(pe_cnt[1]), 32'(exp_pe[1]));
        chk("cnt_serr_b", 32'(se_cnt[1]), 32'(exp_se[1]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
